// File: rtl/operand_input_ctrl_if.sv
// operand_input_ctrl_if: switch/button inputs and committed operand outputs of the calculator front end
interface operand_input_ctrl_if;
    logic [7:0] sw;
    logic       btn_load_a;
    logic       btn_load_b;
    logic       btn_clear;
    logic [7:0] a;
    logic [7:0] b;
    logic       operands_valid;
    logic [1:0] state;
    modport master (
        output sw, btn_load_a, btn_load_b, btn_clear,
        input  a, b, operands_valid, state
    );
    modport slave (
        input  sw, btn_load_a, btn_load_b, btn_clear,
        output a, b, operands_valid, state
    );
endinterface

// File: rtl/operand_input_ctrl.sv
// operand_input_ctrl: synchronizes and debounces three buttons, then commits switch operands A/B
module operand_input_ctrl #(
    parameter int DEBOUNCE_CYCLES = 100_000
) (
    input logic                 clk,
    input logic                 rst,
    operand_input_ctrl_if.slave io
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
    typedef enum logic [1:0] {IDLE = 2'b00, GOT_A = 2'b01, READY = 2'b10} state_t;
    logic [2:0]    raw, s1, s2, deb, deb_d, pulse;
    logic [CW-1:0] cnt [3];
    state_t        st;
    logic [7:0]    a_q, b_q;
    logic          valid_q;
    // bit 0: load_a, bit 1: load_b, bit 2: clear
    assign raw   = {io.btn_clear, io.btn_load_b, io.btn_load_a};
    assign pulse = deb & ~deb_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1    <= '0;
            s2    <= '0;
            deb   <= '0;
            deb_d <= '0;
            for (int i = 0; i < 3; i++) cnt[i] <= '0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            deb_d <= deb;
            for (int i = 0; i < 3; i++) begin
                deb[i] <= (s2[i] != deb[i] && cnt[i] == CNT_MAX) ? s2[i] : deb[i];
                cnt[i] <= (s2[i] == deb[i] || cnt[i] == CNT_MAX) ? '0 : cnt[i] + 1'b1;
            end
        end
    end
    // load_a always lands in GOT_A; load_b only counts once A exists
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st      <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (pulse[2]) begin
                a_q <= '0;
                b_q <= '0;
                st  <= IDLE;
            end else if (pulse[0]) begin
                a_q <= io.sw;
                st  <= GOT_A;
            end else if (pulse[1] && st != IDLE) begin
                b_q     <= io.sw;
                st      <= READY;
                valid_q <= 1'b1;
            end
        end
    end
    assign io.a              = a_q;
    assign io.b              = b_q;
    assign io.operands_valid = valid_q;
    assign io.state          = st;
endmodule

// File: tb/tb_operand_input_ctrl.sv
// tb_operand_input_ctrl: directed scenarios plus random button traffic against a window-based reference model
module tb_operand_input_ctrl;
    localparam int D = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    operand_input_ctrl_if io();
    operand_input_ctrl #(.DEBOUNCE_CYCLES(D)) dut (.clk(clk), .rst(rst), .io(io));
    int total = 0;
    int bad = 0;
    int vcount = 0;
    logic [15:0] exp_q[$];
    logic [15:0] e_pop;
    logic [2:0] raw;
    logic [2:0] m_r1, m_r2, m_deb, m_pend;
    logic [D-1:0] m_hist [3];
    logic [7:0] m_a, m_b;
    logic [1:0] m_st;
    logic m_valid;
    assign raw = {io.btn_clear, io.btn_load_b, io.btn_load_a};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A level change is accepted when the last D synchronized samples all disagree with it
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_r1 <= '0; m_r2 <= '0; m_deb <= '0; m_pend <= '0;
            m_a <= '0; m_b <= '0; m_st <= '0; m_valid <= 1'b0;
            for (int k = 0; k < 3; k++) m_hist[k] <= '0;
            exp_q.delete();
        end else begin
            m_r1 <= raw;
            m_r2 <= m_r1;
            m_valid <= 1'b0;
            for (int k = 0; k < 3; k++) begin
                m_hist[k] <= {m_hist[k][D-2:0], m_r2[k]};
                if ({m_hist[k][D-2:0], m_r2[k]} == {D{~m_deb[k]}}) m_deb[k] <= ~m_deb[k];
                m_pend[k] <= ({m_hist[k][D-2:0], m_r2[k]} == {D{1'b1}}) && !m_deb[k];
            end
            if (m_pend[2]) begin
                m_a <= '0; m_b <= '0; m_st <= 2'b00;
            end else begin
                case (m_st)
                    2'b00: if (m_pend[0]) begin m_a <= io.sw; m_st <= 2'b01; end
                    2'b01: if (m_pend[0]) m_a <= io.sw;
                           else if (m_pend[1]) begin
                               m_b <= io.sw; m_st <= 2'b10; m_valid <= 1'b1;
                               exp_q.push_back({m_a, io.sw});
                           end
                    2'b10: if (m_pend[0]) begin m_a <= io.sw; m_st <= 2'b01; end
                           else if (m_pend[1]) begin
                               m_b <= io.sw; m_valid <= 1'b1;
                               exp_q.push_back({m_a, io.sw});
                           end
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("a_track", 32'(io.a), 32'(m_a));
            check("b_track", 32'(io.b), 32'(m_b));
            check("state_track", 32'(io.state), 32'(m_st));
            check("valid_track", 32'(io.operands_valid), 32'(m_valid));
            if (io.operands_valid) begin
                vcount++;
                if (exp_q.size() == 0) check("valid_unexpected", 1, 0);
                else begin
                    e_pop = exp_q.pop_front();
                    check("sb_a", 32'(io.a), 32'(e_pop[15:8]));
                    check("sb_b", 32'(io.b), 32'(e_pop[7:0]));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int k, input logic [7:0] v, input int n);
        @(negedge clk);
        io.sw = v;
        if (k == 0) io.btn_load_a = 1'b1;
        if (k == 1) io.btn_load_b = 1'b1;
        if (k == 2) io.btn_clear = 1'b1;
        idle(n);
        io.btn_load_a = 1'b0; io.btn_load_b = 1'b0; io.btn_clear = 1'b0;
        idle(D + 6);
    endtask

    initial begin
        int v0;
        io.sw = '0; io.btn_load_a = 1'b0; io.btn_load_b = 1'b0; io.btn_clear = 1'b0;
        idle(2);
        #1;
        check("rst_a", 32'(io.a), 0);
        check("rst_state", 32'(io.state), 0);
        check("rst_valid", 32'(io.operands_valid), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        // commit latency: raw sampled at edge 1 commits at edge D+3
        @(negedge clk);
        io.sw = 8'h5A; io.btn_load_a = 1'b1;
        repeat (D + 2) @(posedge clk);
        #1 check("a_before_edge7", 32'(io.a), 0);
        @(posedge clk);
        #1 check("a_at_edge7", 32'(io.a), 32'h5A);
        check("state_got_a", 32'(io.state), 1);
        idle(3);
        io.btn_load_a = 1'b0;
        idle(D + 6);
        v0 = vcount;
        press(1, 8'hC3, 10);
        check("normal_a", 32'(io.a), 32'h5A);
        check("normal_b", 32'(io.b), 32'hC3);
        check("normal_state", 32'(io.state), 2);
        check("normal_valid_count", vcount - v0, 1);
        // bounce
        press(2, 8'h00, 6);
        io.sw = 8'h11;
        foreach (raw[i]) ;
        begin
            logic [4:0] pat;
            pat = 5'b01101;
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                io.btn_load_a = pat[i];
            end
        end
        io.btn_load_a = 1'b0;
        idle(D + 4);
        check("bounce_no_commit_a", 32'(io.a), 0);
        check("bounce_no_commit_state", 32'(io.state), 0);
        press(0, 8'h22, 10);
        check("bounce_commit_a", 32'(io.a), 32'h22);
        check("bounce_state", 32'(io.state), 1);
        // order / hold
        press(2, 8'h00, 6);
        press(1, 8'h77, 10);
        check("b_in_idle_state", 32'(io.state), 0);
        check("b_in_idle_b", 32'(io.b), 0);
        @(negedge clk);
        io.sw = 8'h33; io.btn_load_a = 1'b1;
        idle(20);
        io.sw = 8'h44;
        idle(30);
        io.btn_load_a = 1'b0;
        idle(D + 6);
        check("hold_a", 32'(io.a), 32'h33);
        check("hold_state", 32'(io.state), 1);
        // simultaneous clear + load_a in READY
        press(1, 8'h55, 8);
        check("ready_state", 32'(io.state), 2);
        @(negedge clk);
        io.sw = 8'h99; io.btn_clear = 1'b1; io.btn_load_a = 1'b1;
        idle(10);
        io.btn_clear = 1'b0; io.btn_load_a = 1'b0;
        idle(D + 6);
        check("simul_a", 32'(io.a), 0);
        check("simul_b", 32'(io.b), 0);
        check("simul_state", 32'(io.state), 0);
        // reset mid-debounce with B held
        press(0, 8'h66, 8);
        @(negedge clk);
        io.sw = 8'hE7; io.btn_load_b = 1'b1;
        idle(3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_a", 32'(io.a), 0);
        check("async_rst_b", 32'(io.b), 0);
        check("async_rst_state", 32'(io.state), 0);
        check("async_rst_valid", 32'(io.operands_valid), 0);
        @(negedge clk);
        #2 rst = 1'b0;
        idle(15);
        io.btn_load_b = 1'b0;
        idle(D + 6);
        check("rst_hold_b", 32'(io.b), 0);
        check("rst_hold_state", 32'(io.state), 0);
        // random traffic
        v0 = vcount;
        for (int s = 0; s < 80; s++) begin
            @(negedge clk);
            io.sw = 8'($urandom);
            io.btn_load_a = 1'($urandom_range(0, 1));
            io.btn_load_b = 1'($urandom_range(0, 1));
            io.btn_clear = ($urandom_range(0, 7) == 0);
            idle($urandom_range(0, 11));
        end
        io.btn_load_a = 1'b0; io.btn_load_b = 1'b0; io.btn_clear = 1'b0;
        idle(20);
        check("sb_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
